// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the arithmetic path and the restoring divider
package arith_pkg;
   localparam int DEFAULT_WIDTH = 4;
   localparam logic [63:0] DIV0_QUOTIENT = '1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division bit: shift in the next dividend bit, trial subtract, restore on borrow
module div_step
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);
   logic [WIDTH:0] shifted, diff;
   assign shifted  = {rem, next_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign q_bit    = ~diff[WIDTH];
   assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle restoring divider, one quotient bit per clock; define SIGNED_DIV_EN for two's-complement operands
module restoring_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             OF
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t           state;
   logic [WIDTH-1:0] dq, divisor, rem, rem_next, x_mag, y_mag, q_raw, q_fin, r_fin;
   logic [CW-1:0]    cnt;
   logic             q_bit;
   assign busy  = state != IDLE;
   assign q_raw = {dq[WIDTH-2:0], q_bit};
`ifdef SIGNED_DIV_EN
   logic neg_q, neg_r, ovf;
   assign x_mag = x[WIDTH-1] ? -x : x;
   assign y_mag = y[WIDTH-1] ? -y : y;
   assign q_fin = neg_q ? -q_raw : q_raw;
   assign r_fin = neg_r ? -rem_next : rem_next;
`else
   assign x_mag = x;
   assign y_mag = y;
   assign q_fin = q_raw;
   assign r_fin = rem_next;
   assign OF    = 1'b0;
`endif
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .next_bit (dq[WIDTH-1]),
      .divisor  (divisor),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );
   // Control FSM; dq shifts the dividend out at the top while quotient bits enter at the bottom
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         dq          <= '0;
         divisor     <= '0;
         rem         <= '0;
         cnt         <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         ovf         <= 1'b0;
         OF          <= 1'b0;
`endif
      end else begin
         done <= state == DONE;
         case (state)
            IDLE: if (start && !done) begin
               dq          <= x_mag;
               divisor     <= y_mag;
               rem         <= '0;
               cnt         <= CW'(WIDTH - 1);
               div_by_zero <= y == '0;
`ifdef SIGNED_DIV_EN
               neg_q       <= x[WIDTH-1] ^ y[WIDTH-1];
               neg_r       <= x[WIDTH-1];
               ovf         <= x == {1'b1, {(WIDTH-1){1'b0}}} && y == '1;
               OF          <= 1'b0;
`endif
               if (y == '0) begin
                  quotient  <= DIV0_QUOTIENT[WIDTH-1:0];
                  remainder <= x;
                  state     <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               dq  <= q_raw;
               rem <= rem_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  quotient  <= q_fin;
                  remainder <= r_fin;
`ifdef SIGNED_DIV_EN
                  OF        <= ovf;
`endif
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and exhaustive checks of restoring_divider against an arithmetic model
module tb_restoring_divider;
   logic       clk = 0, rst_n = 0, start = 0;
   logic [3:0] x = 0, y = 0, quotient, remainder;
   logic       busy, done, div_by_zero, of_flag;
   int         vectors = 0, miscompares = 0;
   int         cyc = 0, start_cyc = 0, exp_done_cyc = 0, done_cyc = 0;
   bit         pending = 0, armed = 0;
   logic [3:0] exp_q = 0, exp_r = 0, mq, mr;
   logic       exp_dz = 0, exp_of = 0, mdz, mof;

   restoring_divider #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .OF(of_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] q, output logic [3:0] r,
                                 output logic dz, output logic of);
      int sa, sb;
      dz = 0; of = 0;
      if (b == 0) begin
         q = 4'hF; r = a; dz = 1;
      end else begin
`ifdef SIGNED_DIV_EN
         sa = $signed(a); sb = $signed(b);
         if (sa == -8 && sb == -1) begin
            q = 4'h8; r = 0; of = 1;
         end else begin
            q = 4'(sa / sb); r = 4'(sa % sb);
         end
`else
         sa = int'(a); sb = int'(b);
         q = 4'(sa / sb); r = 4'(sa % sb);
`endif
      end
   endfunction

   // Every cycle: done/busy timing against the expected schedule, results on done and while held
   always @(negedge clk) begin
      if (rst_n && armed) begin
         if (pending) begin
            check("done_timing", done, cyc == exp_done_cyc);
            check("busy_running", busy, cyc < exp_done_cyc);
            if (cyc == exp_done_cyc) begin
               check("quotient", quotient, exp_q);
               check("remainder", remainder, exp_r);
               check("div_by_zero", div_by_zero, exp_dz);
               check("OF", of_flag, exp_of);
               done_cyc = cyc;
               pending = 0;
            end
         end else begin
            check("done_idle", done, 0);
            check("busy_idle", busy, 0);
            check("quotient_held", quotient, exp_q);
            check("remainder_held", remainder, exp_r);
            check("div_by_zero_held", div_by_zero, exp_dz);
            check("OF_held", of_flag, exp_of);
         end
      end
   end

   task automatic launch(input logic [3:0] a, input logic [3:0] b);
      x = a; y = b; start = 1;
      @(posedge clk); #1;
      start = 0;
      model(a, b, mq, mr, mdz, mof);
      exp_q = mq; exp_r = mr; exp_dz = mdz; exp_of = mof;
      start_cyc = cyc;
      exp_done_cyc = cyc + (b == 0 ? 1 : 5);
      pending = 1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && pending; i++) @(negedge clk);
      if (pending) begin
         vectors++; miscompares++;
         $display("FAIL timeout: done not seen, expected at cycle %0d", exp_done_cyc);
         pending = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b);
      launch(a, b);
      wait_done();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_dbz", div_by_zero, 0);
      check("reset_OF", of_flag, 0);
      armed = 1;
      @(posedge clk); #1;

      model(4'd13, 4'd4, mq, mr, mdz, mof);
`ifdef SIGNED_DIV_EN
      check("model_m3_4_q", mq, 4'h0);
      check("model_m3_4_r", mr, 4'hD);
`else
      check("model_13_4_q", mq, 4'd3);
      check("model_13_4_r", mr, 4'd1);
`endif
      model(4'd7, 4'd0, mq, mr, mdz, mof);
      check("model_7_0_q", mq, 4'hF);
      check("model_7_0_dz", mdz, 1);

      do_op(4'd13, 4'd4);
      check("lat_13_4", done_cyc - start_cyc, 5);
`ifndef SIGNED_DIV_EN
      check("lit_13_4_q", quotient, 4'd3);
      check("lit_13_4_r", remainder, 4'd1);
`endif
      check("lit_13_4_dz", div_by_zero, 0);
      do_op(4'd7, 4'd0);
      check("lat_7_0", done_cyc - start_cyc, 1);
      check("lit_7_0_q", quotient, 4'hF);
      check("lit_7_0_r", remainder, 4'd7);
      check("lit_7_0_dz", div_by_zero, 1);
      do_op(4'd0, 4'd5);
      check("lit_0_5_q", quotient, 4'd0);
      check("lit_0_5_r", remainder, 4'd0);
      do_op(4'd15, 4'd1);
`ifndef SIGNED_DIV_EN
      check("lit_15_1_q", quotient, 4'd15);
      check("lit_15_1_r", remainder, 4'd0);
      do_op(4'd3, 4'd9);
      check("lit_3_9_q", quotient, 4'd0);
      check("lit_3_9_r", remainder, 4'd3);
`else
      do_op(4'h9, 4'd2);
      check("lit_m7_2_q", quotient, 4'hD);
      check("lit_m7_2_r", remainder, 4'hF);
      do_op(4'h8, 4'hF);
      check("lit_m8_m1_q", quotient, 4'h8);
      check("lit_m8_m1_r", remainder, 4'h0);
      check("lit_m8_m1_OF", of_flag, 1);
`endif

      // start during RUN is ignored
      launch(4'd13, 4'd4);
      @(posedge clk); #1;
      x = 4'd2; y = 4'd1; start = 1;
      @(posedge clk); #1;
      start = 0;
      wait_done();
`ifndef SIGNED_DIV_EN
      check("ignored_start_q", quotient, 4'd3);
      check("ignored_start_r", remainder, 4'd1);
`endif

      // start in the done cycle is ignored
      launch(4'd6, 4'd3);
      for (int i = 0; i < 20 && !done; i++) @(negedge clk);
      check("done_seen_6_3", done, 1);
      x = 4'd9; y = 4'd2; start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      check("start_on_done_ignored", busy, 0);
      @(posedge clk); #1;

      // reset during RUN aborts
      launch(4'd13, 4'd4);
      @(posedge clk); #1;
      rst_n = 0; pending = 0;
      @(posedge clk); #1;
      rst_n = 1;
      exp_q = 0; exp_r = 0; exp_dz = 0; exp_of = 0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      @(posedge clk); #1;
      do_op(4'd13, 4'd4);
      check("after_abort_lat", done_cyc - start_cyc, 5);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            do_op(4'(a), 4'(b));
            if (b != 0 && !exp_of)
               check("invariant", 4'(int'(quotient) * b + int'(remainder)), 4'(a));
         end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
